// File: rtl/async_register_pkg.sv
// Shared types and defaults for the toggle-handshake register receiver.
`timescale 1ns/1ps
package async_register_pkg;

    localparam int DEFAULT_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        VERIFY  = 2'd2,
        PRESENT = 2'd3
    } rx_state_t;

endpackage

// File: rtl/async_rx_sync.sv
// Single-bit flop-chain synchroniser for the incoming request toggle.
`timescale 1ns/1ps
module async_rx_sync
    import async_register_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES   // legal 2..4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic asyncIn,
    output logic syncOut
);

    // Pure flop chain: any gate between these stages would defeat metastability settling.
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] syncFf;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) syncFf <= '0;
        else        syncFf <= {syncFf[SYNC_STAGES-2:0], asyncIn};
    end

    assign syncOut = syncFf[SYNC_STAGES-1];

endmodule

// File: rtl/async_register_rx.sv
// Receive end of a toggle-handshake register crossing into clk.
// Optional capture re-check enabled by defining ASYNC_REGISTER_RX_STABLE_CHECK_EN.
`timescale 1ns/1ps
module async_register_rx
    import async_register_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_tog_i,
    input  logic [WIDTH-1:0]       data_i,
    output logic                   ack_tog_o,
    output logic [WIDTH-1:0]       data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [COUNT_WIDTH-1:0] update_count_o,
    output logic                   stab_err_o
);

    rx_state_t              state, nextState;
    logic                   reqSync, reqSeen;
    logic [WIDTH-1:0]       dataQ;
    logic                   ackTog;
    logic [COUNT_WIDTH-1:0] updateCount;
    logic                   handshake;

    async_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) reqSyncInst (
        .clk     (clk),
        .rst_n   (rst_n),
        .asyncIn (req_tog_i),
        .syncOut (reqSync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    // NOTE: nextState is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (reqSync != reqSeen) nextState = CAPTURE;
`ifdef ASYNC_REGISTER_RX_STABLE_CHECK_EN
            CAPTURE: nextState = VERIFY;
            VERIFY:  if (data_i == dataQ) nextState = PRESENT;
`else
            CAPTURE: nextState = PRESENT;
            VERIFY:  nextState = IDLE;
`endif
            PRESENT: if (ready_i) nextState = IDLE;
        endcase
    end

    assign handshake = (state == PRESENT) && ready_i;

    // NOTE: dataQ is a single word of flops, so it takes the async reset like the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reqSeen     <= 1'b0;
            dataQ       <= '0;
            ackTog      <= 1'b0;
            updateCount <= '0;
        end else begin
            // Taking reqSync here collapses any extra source toggles into one transfer.
            if (state == CAPTURE) begin
                dataQ   <= data_i;
                reqSeen <= reqSync;
            end
`ifdef ASYNC_REGISTER_RX_STABLE_CHECK_EN
            if (state == VERIFY && data_i != dataQ) dataQ <= data_i;
`endif
            if (handshake) begin
                ackTog      <= ~ackTog;
                updateCount <= updateCount + COUNT_WIDTH'(1);
            end
        end
    end

`ifdef ASYNC_REGISTER_RX_STABLE_CHECK_EN
    logic stabErr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stabErr <= 1'b0;
        else        stabErr <= (state == VERIFY) && (data_i != dataQ);
    end

    assign stab_err_o = stabErr;
`else
    assign stab_err_o = 1'b0;
`endif

    assign ack_tog_o      = ackTog;
    assign data_o         = dataQ;
    assign valid_o        = (state == PRESENT);
    assign update_count_o = updateCount;

endmodule

// File: tb/tb_async_register_rx.sv
// Directed bench for async_register_rx; a second instance with COUNT_WIDTH=4 covers wrap.
`timescale 1ns/1ps
module tb_async_register_rx;

    localparam int WIDTH = 32;
    localparam int SYNC  = 2;
`ifdef ASYNC_REGISTER_RX_STABLE_CHECK_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT = SYNC + 2 + EXTRA;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             req    = 1'b0;
    logic             ready  = 1'b0;
    logic [WIDTH-1:0] dataIn = '0;

    wire              ack, valid, stabErr;
    wire [WIDTH-1:0]  dataOut;
    wire [15:0]       cnt;
    wire              ack4, valid4, stabErr4;
    wire [WIDTH-1:0]  dataOut4;
    wire [3:0]        cnt4;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    async_register_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .COUNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_tog_i(req), .data_i(dataIn),
        .ack_tog_o(ack), .data_o(dataOut), .valid_o(valid), .ready_i(ready),
        .update_count_o(cnt), .stab_err_o(stabErr)
    );

    async_register_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .COUNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req_tog_i(req), .data_i(dataIn),
        .ack_tog_o(ack4), .data_o(dataOut4), .valid_o(valid4), .ready_i(ready),
        .update_count_o(cnt4), .stab_err_o(stabErr4)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 1'b0;
        ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: valid_o=%b after %0d cycles, required 1", name, valid, n);
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input string name);
        logic target;
        int   n = 0;
        dataIn = d;
        target = ~ack;
        @(negedge clk);
        req = ~req;
        while (ack !== target && n < 100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (ack !== target) begin
            miscompares++;
            $display("FAIL %s: ack_tog_o=%b after %0d cycles, required %b", name, ack, n, target);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req = ~req;
            vectors++;
            if (valid !== 1'b0 || ack !== 1'b0 || dataOut !== '0 || cnt !== '0) begin
                miscompares++;
                $display("FAIL reset_hold cycle %0d: valid=%b ack=%b data=%h count=%0d, required 0/0/0/0",
                         i, valid, ack, dataOut, cnt);
            end
        end
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        do_reset();
        ready  = 1'b1;
        dataIn = 32'hDEADBEEF;
        @(negedge clk);
        req = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            vectors++;
            if (valid !== (k == LAT)) begin
                miscompares++;
                $display("FAIL single_latency cycle %0d: valid_o=%b, required %b", k, valid, (k == LAT));
            end
        end
        vectors++;
        if (dataOut !== 32'hDEADBEEF || ack !== 1'b0) begin
            miscompares++;
            $display("FAIL single_data: data_o=%h ack=%b, required deadbeef/0", dataOut, ack);
        end
        @(negedge clk);
        vectors++;
        if (valid !== 1'b0 || ack !== 1'b1 || cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL single_ack: valid=%b ack=%b count=%0d, required 0/1/1", valid, ack, cnt);
        end
    endtask

    task automatic test_backpressure();
        ready = 1'b0;
        @(negedge clk);
        req = 1'b0;
        wait_valid("bp_valid");
        dataIn = 32'h0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if (valid !== 1'b1 || dataOut !== 32'hDEADBEEF || ack !== 1'b1 || cnt !== 16'd1 || stabErr !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold cycle %0d: valid=%b data=%h ack=%b count=%0d stab=%b, required 1/deadbeef/1/1/0",
                         i, valid, dataOut, ack, cnt, stabErr);
            end
        end
        ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (valid !== 1'b0 || ack !== 1'b0 || cnt !== 16'd2) begin
            miscompares++;
            $display("FAIL bp_release: valid=%b ack=%b count=%0d, required 0/0/2", valid, ack, cnt);
        end
        ready = 1'b0;
    endtask

    task automatic test_stream();
        int got   = 0;
        bit abort = 1'b0;
        do_reset();
        fork
            begin : source
                for (int i = 0; i < 1000 && !abort; i++) begin
                    logic target;
                    int   t = 0;
                    #($urandom_range(0, 13));
                    dataIn = WIDTH'(i);
                    #($urandom_range(1, 7));
                    target = ~ack;
                    req    = ~req;
                    while (ack !== target && t < 2000) begin
                        #1;
                        t++;
                    end
                    if (ack !== target) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL stream_ack_timeout at word %0d: ack_tog_o=%b, required %b", i, ack, target);
                        abort = 1'b1;
                    end
                end
            end
            begin : sink
                int budget = 0;
                while (got < 1000 && budget < 60000 && !abort) begin
                    @(negedge clk);
                    ready = 1'($urandom_range(0, 1));
                    if (valid === 1'b1 && ready) begin
                        vectors++;
                        if (dataOut !== WIDTH'(got)) begin
                            miscompares++;
                            $display("FAIL stream_order: data_o=%0d, required %0d", dataOut, got);
                        end
                        got++;
                    end
                    budget++;
                end
            end
        join
        ready = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        vectors++;
        if (got != 1000 || cnt !== 16'd1000 || valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_total: received=%0d count=%0d valid=%b, required 1000/1000/0", got, cnt, valid);
        end
    endtask

    task automatic test_wrap_reset();
        do_reset();
        ready = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            send(WIDTH'(i * 3), "wrap_ack");
            vectors++;
            if (cnt4 !== 4'(i) || cnt !== 16'(i)) begin
                miscompares++;
                $display("FAIL wrap_count transfer %0d: count4=%0d count16=%0d, required %0d/%0d",
                         i, cnt4, cnt, i % 16, i);
            end
        end
        ready = 1'b0;
        dataIn = 32'h12345678;
        @(negedge clk);
        req = ~req;
        wait_valid("reset_mid_valid");
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (valid !== 1'b0 || ack !== 1'b0 || dataOut !== '0 || cnt !== '0 ||
            valid4 !== 1'b0 || ack4 !== 1'b0 || dataOut4 !== '0 || cnt4 !== '0 || stabErr4 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: valid=%b ack=%b data=%h count=%0d valid4=%b ack4=%b count4=%0d, required all 0",
                     valid, ack, dataOut, cnt, valid4, ack4, cnt4);
        end
        req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

`ifdef ASYNC_REGISTER_RX_STABLE_CHECK_EN
    task automatic test_stable_check();
        do_reset();
        ready  = 1'b1;
        dataIn = 32'hA5A5A5A5;
        @(negedge clk);
        req = 1'b1;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            vectors++;
            if (valid !== (k == LAT + 1) || stabErr !== (k == LAT)) begin
                miscompares++;
                $display("FAIL stab_cycle %0d: valid=%b stab_err=%b, required %b/%b",
                         k, valid, stabErr, (k == LAT + 1), (k == LAT));
            end
            if (k == SYNC + 2) dataIn = 32'h5A5A5A5A;
        end
        vectors++;
        if (dataOut !== 32'h5A5A5A5A) begin
            miscompares++;
            $display("FAIL stab_data: data_o=%h, required 5a5a5a5a", dataOut);
        end
        ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_stream();
        test_wrap_reset();
`ifdef ASYNC_REGISTER_RX_STABLE_CHECK_EN
        test_stable_check();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
